// File: rtl/alu_operand_loader.sv
// Collects operands A, B and an opcode from a shared switch bus, one item per rising edge of load.
// Presents them as a stable, valid operand set once all three have been captured.
module alu_operand_loader #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned OPW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [OPW-1:0]   op,
  output logic             valid,
  output logic             done_pulse,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StA    = 2'b00,
    StB    = 2'b01,
    StOp   = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic             valid_q, done_q;
  logic             load_q;
  // Set when load was high across reset release; masks the edge until load drops.
  logic             block_q;
  logic             load_rise;

  assign load_rise = load & ~load_q & ~block_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StA;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      block_q <= load;
    end else begin
      load_q  <= load;
      block_q <= block_q & load;
      done_q  <= 1'b0;
      if (clear) begin
        state_q <= StA;
        a_q     <= '0;
        b_q     <= '0;
        op_q    <= '0;
        valid_q <= 1'b0;
      end else if (load_rise) begin
        unique case (state_q)
          StA: begin
            a_q     <= data_in;
            state_q <= StB;
          end
          StB: begin
            b_q     <= data_in;
            state_q <= StOp;
          end
          StOp: begin
            op_q    <= data_in[OPW-1:0];
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
          StDone: begin
            // New A starts the next set; B and op are kept until overwritten.
            a_q     <= data_in;
            valid_q <= 1'b0;
            state_q <= StB;
          end
        endcase
      end
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign op         = op_q;
  assign valid      = valid_q;
  assign done_pulse = done_q;
  assign state      = state_q;

endmodule
